// File: rtl/sample_deser.sv
// sample_deser: collects serial samples into NB_OUT parallel lanes and
// presents each complete frame on data_out with a one-cycle strobe.
//
// Ports:
//   clk          rising-edge clock
//   areset       asynchronous active-high reset
//   data_in      serial sample (DATA_WIDTH bits)
//   data_in_en   data_in valid this cycle
//   frame_start  qualified by data_in_en; current sample is lane 0
//   data_out     assembled frame, lane k = k-th sample of the frame
//   data_out_en  one-cycle strobe, data_out holds a new frame
//   lane_cnt     index of the next lane to be written
//   frame_err    one-cycle pulse, a partial frame was discarded
//   flush        (only with SAMPLE_DESER_FLUSH_EN) emit the partial frame
//                zero-padded
//
// Optional feature macro: SAMPLE_DESER_FLUSH_EN
module sample_deser #(
  parameter int unsigned NB_OUT     = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = $clog2(NB_OUT)
) (
  input  logic                                clk,
  input  logic                                areset,
  input  logic [DATA_WIDTH-1:0]               data_in,
  input  logic                                data_in_en,
  input  logic                                frame_start,
  output logic [NB_OUT-1:0][DATA_WIDTH-1:0]   data_out,
  output logic                                data_out_en,
  output logic [CNT_WIDTH-1:0]                lane_cnt,
  output logic                                frame_err
`ifdef SAMPLE_DESER_FLUSH_EN
  ,
  input  logic                                flush
`endif
);

  localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(NB_OUT - 1);

  logic [NB_OUT-1:0][DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [NB_OUT-1:0][DATA_WIDTH-1:0] out_q, out_d;
  logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;
  logic                              out_en_q, out_en_d;
  logic                              err_q, err_d;

  logic resync;
  logic last;
  logic flush_req;

  // Next-state: lane write, frame completion, resync and optional flush
  always_comb begin
    shadow_d = shadow_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    out_en_d = 1'b0;
    err_d    = 1'b0;

    resync = data_in_en && frame_start && (cnt_q != '0);
    last   = (cnt_q == LAST_LANE);

`ifdef SAMPLE_DESER_FLUSH_EN
    // frame_start with a sample owns the cycle; flush is ignored then
    flush_req = flush && !(data_in_en && frame_start) &&
                (data_in_en || (cnt_q != '0));
`else
    flush_req = 1'b0;
`endif

    if (resync) begin
      // Drop the partial frame; this sample opens a new one in lane 0.
      // Also covers the case where it would have completed the frame.
      shadow_d[0] = data_in;
      cnt_d       = CNT_WIDTH'(1);
      err_d       = 1'b1;
    end else begin
      if (data_in_en) begin
        for (int unsigned k = 0; k < NB_OUT; k++) begin
          if (CNT_WIDTH'(k) == cnt_q) begin
            shadow_d[k] = data_in;
          end
        end
        if (last) begin
          cnt_d    = '0;
          out_d    = shadow_d;
          out_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      // Flush: written lanes pass through, the rest are zero-padded
      if (flush_req && !(data_in_en && last)) begin
        for (int unsigned k = 0; k < NB_OUT; k++) begin
          if (data_in_en ? (CNT_WIDTH'(k) <= cnt_q) : (CNT_WIDTH'(k) < cnt_q)) begin
            out_d[k] = shadow_d[k];
          end else begin
            out_d[k] = '0;
          end
        end
        out_en_d = 1'b1;
        cnt_d    = '0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      shadow_q <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      out_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      out_en_q <= out_en_d;
      err_q    <= err_d;
    end
  end

  assign data_out    = out_q;
  assign data_out_en = out_en_q;
  assign lane_cnt    = cnt_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_sample_deser.sv
module tb_sample_deser;

  localparam int unsigned NB_OUT     = 8;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned CNT_WIDTH  = 3;

  logic                              clk;
  logic                              areset;
  logic [DATA_WIDTH-1:0]             data_in;
  logic                              data_in_en;
  logic                              frame_start;
  logic [NB_OUT-1:0][DATA_WIDTH-1:0] data_out;
  logic                              data_out_en;
  logic [CNT_WIDTH-1:0]              lane_cnt;
  logic                              frame_err;
`ifdef SAMPLE_DESER_FLUSH_EN
  logic                              flush;
`endif

  int total;
  int bad;
  int strobe_cnt;
  int err_cnt;
  int base_strobe;
  int base_err;
  logic [DATA_WIDTH-1:0] exp_lane [NB_OUT];

  sample_deser #(
    .NB_OUT(NB_OUT),
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .areset(areset),
    .data_in(data_in),
    .data_in_en(data_in_en),
    .frame_start(frame_start),
    .data_out(data_out),
    .data_out_en(data_out_en),
    .lane_cnt(lane_cnt),
    .frame_err(frame_err)
`ifdef SAMPLE_DESER_FLUSH_EN
    ,
    .flush(flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  initial begin
    strobe_cnt = 0;
    err_cnt    = 0;
  end
  always @(negedge clk) begin
    if (data_out_en) strobe_cnt = strobe_cnt + 1;
    if (frame_err)   err_cnt    = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag);
    for (int k = 0; k < NB_OUT; k++) begin
      check($sformatf("%s lane%0d", tag, k), 32'(data_out[k]), 32'(exp_lane[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_WIDTH-1:0] d, input logic fs);
    data_in     = d;
    frame_start = fs;
    data_in_en  = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    data_in_en  = 1'b0;
    frame_start = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    areset      = 1'b1;
    data_in     = '0;
    data_in_en  = 1'b0;
    frame_start = 1'b0;
`ifdef SAMPLE_DESER_FLUSH_EN
    flush       = 1'b0;
`endif

    // Reset state
    #12;
    for (int k = 0; k < NB_OUT; k++) exp_lane[k] = '0;
    check_frame("reset data_out");
    check("reset lane_cnt", 32'(lane_cnt), 32'd0);
    check("reset data_out_en", 32'(data_out_en), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    areset = 1'b0;

    // One frame 1..8, strobe the cycle after the 8th sample
    base_strobe = strobe_cnt;
    for (int i = 1; i <= 7; i++) send(DATA_WIDTH'(i), 1'b0);
    check("no early strobe", 32'(data_out_en), 32'd0);
    check("lane_cnt before last", 32'(lane_cnt), 32'd7);
    send(DATA_WIDTH'(8), 1'b0);
    check("frame1 strobe", 32'(data_out_en), 32'd1);
    check("frame1 lane_cnt wrap", 32'(lane_cnt), 32'd0);
    for (int k = 0; k < NB_OUT; k++) exp_lane[k] = DATA_WIDTH'(k + 1);
    check_frame("frame1");
    idle(1);
    check("frame1 strobe one cycle", 32'(data_out_en), 32'd0);
    check_frame("frame1 held");
    idle(1);
    check("frame1 strobe count", 32'(strobe_cnt - base_strobe), 32'd1);

    // 24 continuous samples: strobe every 8 cycles with no gap
    base_strobe = strobe_cnt;
    for (int i = 0; i < 24; i++) begin
      send(DATA_WIDTH'(i), 1'b0);
      if ((i % 8) == 7) begin
        check($sformatf("stream strobe @%0d", i), 32'(data_out_en), 32'd1);
        for (int k = 0; k < NB_OUT; k++) exp_lane[k] = DATA_WIDTH'(i - 7 + k);
        check_frame($sformatf("stream frame @%0d", i));
      end else begin
        check($sformatf("stream no strobe @%0d", i), 32'(data_out_en), 32'd0);
      end
    end
    idle(2);
    check("stream strobe count", 32'(strobe_cnt - base_strobe), 32'd3);

    // frame_start at lane 0 is not an error; at lane 3 it discards A,B,C
    base_err    = err_cnt;
    base_strobe = strobe_cnt;
    send(16'h000A, 1'b1);
    check("fs at lane0 no err", 32'(frame_err), 32'd0);
    send(16'h000B, 1'b0);
    send(16'h000C, 1'b0);
    send(16'h000D, 1'b1);
    check("resync err pulse", 32'(frame_err), 32'd1);
    check("resync lane_cnt", 32'(lane_cnt), 32'd1);
    check("resync no strobe", 32'(data_out_en), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      send(DATA_WIDTH'(16'h20 + i), 1'b0);
      if (i == 1) check("resync err one cycle", 32'(frame_err), 32'd0);
    end
    check("resync frame strobe", 32'(data_out_en), 32'd1);
    exp_lane[0] = 16'h000D;
    for (int k = 1; k < NB_OUT; k++) exp_lane[k] = DATA_WIDTH'(16'h20 + k);
    check_frame("resync frame");
    idle(2);
    check("resync err count", 32'(err_cnt - base_err), 32'd1);
    check("resync strobe count", 32'(strobe_cnt - base_strobe), 32'd1);

    // frame_start on the would-be last lane: resync only
    base_strobe = strobe_cnt;
    for (int i = 0; i < 7; i++) send(DATA_WIDTH'(16'h30 + i), 1'b0);
    send(16'h0040, 1'b1);
    check("late resync no strobe", 32'(data_out_en), 32'd0);
    check("late resync err", 32'(frame_err), 32'd1);
    check("late resync lane_cnt", 32'(lane_cnt), 32'd1);
    for (int i = 1; i <= 7; i++) send(DATA_WIDTH'(16'h40 + i), 1'b0);
    check("late resync frame strobe", 32'(data_out_en), 32'd1);
    for (int k = 0; k < NB_OUT; k++) exp_lane[k] = DATA_WIDTH'(16'h40 + k);
    check_frame("late resync frame");
    idle(2);
    check("late resync strobe count", 32'(strobe_cnt - base_strobe), 32'd1);

    // 5 samples with idle gaps; junk and frame_start ignored while idle
    base_strobe = strobe_cnt;
    base_err    = err_cnt;
    for (int i = 0; i < 5; i++) begin
      send(DATA_WIDTH'(16'h50 + i), 1'b0);
      data_in_en  = 1'b0;
      frame_start = 1'b1;
      data_in     = 16'hDEAD;
      for (int g = 0; g < int'($urandom_range(1, 4)); g++) tick();
    end
    frame_start = 1'b0;
    check("gaps lane_cnt", 32'(lane_cnt), 32'd5);
    check("gaps strobe count", 32'(strobe_cnt - base_strobe), 32'd0);
    check("gaps err count", 32'(err_cnt - base_err), 32'd0);
    check_frame("gaps data_out held");

    // Reset mid-frame: everything clears asynchronously
    areset = 1'b1;
    #2;
    check("midreset lane_cnt", 32'(lane_cnt), 32'd0);
    check("midreset lane0", 32'(data_out[0]), 32'd0);
    check("midreset lane7", 32'(data_out[7]), 32'd0);
    areset = 1'b0;
    idle(1);
    base_strobe = strobe_cnt;
    for (int i = 0; i < 7; i++) send(DATA_WIDTH'(16'h10 + i), 1'b0);
    check("post reset no stale strobe", 32'(data_out_en), 32'd0);
    send(16'h0017, 1'b0);
    check("post reset strobe", 32'(data_out_en), 32'd1);
    for (int k = 0; k < NB_OUT; k++) exp_lane[k] = DATA_WIDTH'(16'h10 + k);
    check_frame("post reset frame");
    idle(2);
    check("post reset strobe count", 32'(strobe_cnt - base_strobe), 32'd1);

`ifdef SAMPLE_DESER_FLUSH_EN
    // Flush a 3-sample partial frame with zero padding
    send(16'd7, 1'b0);
    send(16'd8, 1'b0);
    send(16'd9, 1'b0);
    data_in_en = 1'b0;
    flush      = 1'b1;
    tick();
    flush = 1'b0;
    check("flush strobe", 32'(data_out_en), 32'd1);
    check("flush lane_cnt", 32'(lane_cnt), 32'd0);
    exp_lane[0] = 16'd7;
    exp_lane[1] = 16'd8;
    exp_lane[2] = 16'd9;
    for (int k = 3; k < NB_OUT; k++) exp_lane[k] = '0;
    check_frame("flush frame");
    tick();
    check("flush strobe one cycle", 32'(data_out_en), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush empty no strobe", 32'(data_out_en), 32'd0);
    check_frame("flush empty held");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule

// File: doc/sample_deser.md
SAMPLE_DESER -- requirements
Module: sample_deser

Interface
REQ-001 SHALL have parameter NB_OUT, default 8, number of parallel output lanes (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, bit width of each sample.
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(NB_OUT), width of the lane counter.
REQ-004 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port: areset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: data_in  input  DATA_WIDTH  serial sample.
REQ-007 SHALL have port: data_in_en  input  1  data_in valid this cycle.
REQ-008 SHALL have port: frame_start  input  1  qualified by data_in_en; current sample is lane 0 of a new frame.
REQ-009 SHALL have port: data_out  output  array [NB_OUT-1:0] of DATA_WIDTH  assembled frame; lane k is the k-th sample of the frame.
REQ-010 SHALL have port: data_out_en  output  1  one-cycle strobe; data_out holds a complete new frame.
REQ-011 SHALL have port: lane_cnt  output  CNT_WIDTH  index of the next lane to be written.
REQ-012 SHALL have port: frame_err  output  1  one-cycle pulse; partial frame discarded.

Function
REQ-013 SHALL, on each cycle with data_in_en=1, write data_in into shadow lane lane_cnt and increment lane_cnt.
REQ-014 SHALL, when the write targets lane NB_OUT-1, wrap lane_cnt to 0, copy the full shadow vector (including this sample) to data_out on the next edge, and pulse data_out_en for exactly one cycle.
REQ-015 SHALL have a latency of 1 cycle: data_out_en is high in the cycle after the edge that accepts the last sample.
REQ-016 SHALL hold data_out stable between strobes; partially filled frames never appear on data_out.
REQ-017 SHALL ignore data_in and frame_start while data_in_en=0; lane_cnt holds.
REQ-018 SHALL, on data_in_en=1 with frame_start=1 and lane_cnt=0, behave exactly as REQ-013 with no error.
REQ-019 SHALL, on data_in_en=1 with frame_start=1 and lane_cnt!=0, discard the partial frame, write the sample to lane 0, set lane_cnt=1, and pulse frame_err next cycle.
REQ-020 SHALL, when frame_start resynchronises and NB_OUT would otherwise complete in the same cycle, resynchronise only (no data_out_en).
REQ-021 SHALL accept back-to-back samples every cycle; consecutive frames yield data_out_en every NB_OUT cycles with no gap.
REQ-022 SHALL copy samples verbatim; no arithmetic, no sign handling.

Reset
REQ-023 SHALL, while areset=1, asynchronously clear data_out (all lanes 0), shadow lanes, lane_cnt=0, data_out_en=0, frame_err=0.
REQ-024 SHALL, on reset mid-frame, lose the partial frame; the first sample after release lands in lane 0.

Configuration
REQ-025 SHALL support macro SAMPLE_DESER_FLUSH_EN; when defined, add input port flush (1 bit).
REQ-026 SHALL, with SAMPLE_DESER_FLUSH_EN defined and flush=1 while lane_cnt!=0 (or a sample is accepted in the same cycle), zero-fill unwritten lanes, present the frame next cycle with data_out_en, and set lane_cnt=0.
REQ-027 SHALL, with SAMPLE_DESER_FLUSH_EN defined, store a sample accepted in the flush cycle before padding; flush with lane_cnt=0 and no sample has no effect; frame_start takes priority over flush.
REQ-028 SHALL, without SAMPLE_DESER_FLUSH_EN, omit the flush port and logic; partial frames complete only via REQ-014.

Verification
REQ-029 Reset then NB_OUT=8 samples 1..8 on consecutive cycles -> one data_out_en, cycle after the 8th; data_out lanes 0..7 = 1..8.
REQ-030 24 continuous samples 0..23 -> data_out_en on 3 cycles spaced 8 apart; frames {0..7},{8..15},{16..23}.
REQ-031 3 samples (A,B,C), then frame_start with sample D, then 7 more -> frame_err pulse once; frame = D followed by the 7; A,B,C absent.
REQ-032 5 samples with data_in_en gaps of random length -> lane_cnt=5, no data_out_en; data_out still previous frame.
REQ-033 areset pulse after 4 samples, then 8 samples 0x10..0x17 -> data_out = 0x10..0x17; no strobe from the stale partial frame.
REQ-034 (SAMPLE_DESER_FLUSH_EN) 3 samples 7,8,9 then flush -> data_out = {7,8,9,0,0,0,0,0}, data_out_en one cycle, lane_cnt=0.
